// File: rtl/mdr_pull_stage.sv
// Memory data register pull stage: issues a read, waits (bounded) for mem_ack,
// captures mem_din into mdr_q and gates it onto the bus only while the word is held.
module mdr_pull_stage #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_start,
  input  logic        mem_ack,
  input  logic [31:0] mem_din,
  input  logic        pull_req,
  output logic        mem_as,
  output logic [31:0] mdr_q,
  output logic        pullD,
  output logic        busy,
  output logic        done,
  output logic        tmo_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    HOLD     = 2'd2
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  // Handshake: rd_start is a one-cycle request with no ready; it is taken in
  // IDLE or HOLD and dropped in WAIT_ACK. mem_ack qualifies mem_din only in WAIT_ACK.
  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mdr_d;
  logic        done_q, done_d;
  logic        tmo_err_q, tmo_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      mdr_q     <= 32'h0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mdr_q     <= mdr_d;
      done_q    <= done_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (rd_start) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (mem_ack)                 state_d = HOLD;
        else if (cnt_q == LAST_WAIT) state_d = IDLE;
      end
      HOLD:     if (rd_start) state_d = WAIT_ACK;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    mdr_d     = mdr_q;
    done_d    = 1'b0;
    tmo_err_d = tmo_err_q;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          cnt_d     = 8'd0;
          tmo_err_d = 1'b0;
        end
      end
      WAIT_ACK: begin
        // Ack has priority over the timeout on the last wait cycle.
        if (mem_ack) begin
          mdr_d  = mem_din;
          done_d = 1'b1;
        end else if (cnt_q == LAST_WAIT) begin
          tmo_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (rd_start) cnt_d = 8'd0;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_as  = (state_q == WAIT_ACK);
    busy    = (state_q != IDLE);
    pullD   = pull_req && (state_q == HOLD);
    done    = done_q;
    tmo_err = tmo_err_q;
  end

endmodule

// File: doc/mdr_pull_stage.md
MDR_PULL_STAGE -- requirements
Module: mdr_pull_stage

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT, default 15, the maximum number of cycles spent waiting for mem_ack (legal range 1..255).
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rd_start  input  1  one-cycle request to begin a memory read.
REQ-006 mem_ack  input  1  memory acknowledge; mem_din is valid in any cycle in which mem_ack=1.
REQ-007 mem_din  input  32  read data returned by memory.
REQ-008 pull_req  input  1  datapath request to drive the captured word onto the bus.
REQ-009 mem_as  output  1  address strobe to memory; it SHALL be high throughout WAIT_ACK.
REQ-010 mdr_q  output  32  captured data word; it feeds Din of the downstream bus gate.
REQ-011 pullD  output  1  bus-drive enable; it feeds pullD of the downstream bus gate.
REQ-012 busy  output  1  high while the state is not IDLE.
REQ-013 done  output  1  one-cycle pulse on the cycle after data capture.
REQ-014 tmo_err  output  1  sticky timeout flag.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT_ACK and HOLD, all registered.
REQ-016 IDLE with rd_start=1 SHALL move to WAIT_ACK on the next edge, SHALL clear the wait counter, and SHALL clear tmo_err.
REQ-017 In WAIT_ACK the wait counter SHALL increment by 1 each cycle while mem_ack=0.
REQ-018 WAIT_ACK with mem_ack=1 SHALL capture mem_din into mdr_q on that edge and SHALL move to HOLD; data capture latency is 1 cycle after ack.
REQ-019 WAIT_ACK with mem_ack=0 and counter=TIMEOUT-1 SHALL move to IDLE and SHALL set tmo_err=1; mdr_q SHALL be left unchanged.
REQ-020 If mem_ack=1 arrives in the same cycle as the timeout condition, the ack SHALL win: data is captured and tmo_err is not set.
REQ-021 done SHALL be registered and SHALL be high for exactly the first cycle in HOLD.
REQ-022 HOLD SHALL persist while mdr_q stays valid; rd_start in HOLD SHALL move to WAIT_ACK (a new read); in all other cases the state SHALL remain HOLD.
REQ-023 pullD SHALL be combinational: pull_req AND (state==HOLD).
REQ-024 pullD SHALL be 0 in IDLE and in WAIT_ACK regardless of pull_req, so the bus never sees a stale or in-flight word.
REQ-025 rd_start in WAIT_ACK SHALL be ignored and SHALL NOT restart the counter.
REQ-026 mem_ack in IDLE or HOLD SHALL be ignored, and mdr_q SHALL NOT change.
REQ-027 mdr_q SHALL change only on a WAIT_ACK capture edge.
REQ-028 The wait counter SHALL be 8 bits and SHALL never wrap, because it resets on every WAIT_ACK entry.
REQ-029 tmo_err SHALL stay set until the next rd_start accepted from IDLE, or until reset.

Reset
REQ-030 When rst_n=0 the module SHALL asynchronously force: state=IDLE, mdr_q=32'h0, counter=0, done=0, tmo_err=0, mem_as=0, busy=0, pullD=0.
REQ-031 Reset asserted mid-WAIT_ACK or mid-HOLD SHALL abort the operation immediately; a mem_ack arriving during reset SHALL be discarded.
REQ-032 Reset release SHALL be synchronous to clk, and the first rd_start SHALL be accepted on the first edge with rst_n=1.

Verification
REQ-033 Nominal read: rd_start, then mem_ack=1 with mem_din=32'hDEADBEEF 3 cycles later -> mdr_q=DEADBEEF, done pulses once, busy=1 from the edge after rd_start until reset or timeout.
REQ-034 Gated pull: in HOLD with pull_req=1 -> pullD=1; the same pull_req in WAIT_ACK -> pullD=0.
REQ-035 Timeout with TIMEOUT=4 and no ack: rd_start -> IDLE after 4 WAIT_ACK cycles, tmo_err=1, mdr_q unchanged; the next rd_start clears tmo_err.
REQ-036 Ack at the timeout boundary (counter=TIMEOUT-1, mem_ack=1, mem_din=32'h12345678) -> HOLD, mdr_q=12345678, tmo_err=0.
REQ-037 Reset mid-WAIT_ACK: rst_n=0 for one cycle while mem_ack=1 -> IDLE, mdr_q=0, no done pulse.
REQ-038 Back-to-back reads: rd_start in HOLD -> WAIT_ACK; mdr_q holds the old word until the new ack; pullD=0 during the wait.
